// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC sequencing, RUN/HALT control and a small decode-side buffer.
// Optional FETCH_QUEUE_EN macro: 2-entry buffer instead of a single register.
module inst_fetch #(
   parameter int         WORD_SIZE = 32,
   parameter logic [3:0] HALT_OP   = 4'b1111
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 redirect,
   input  logic [WORD_SIZE-1:0] redirect_pc,
   output logic [WORD_SIZE-1:0] ptr,
   input  logic [WORD_SIZE-1:0] inst_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_inst,
   output logic [WORD_SIZE-1:0] out_pc,
   output logic                 halted
);

`ifdef FETCH_QUEUE_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   typedef enum logic {ST_RUN, ST_HALT} state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [WORD_SIZE-1:0] r_pc;
   logic [WORD_SIZE-1:0] r_buf_inst [DEPTH];
   logic [WORD_SIZE-1:0] r_buf_pc   [DEPTH];
   logic [WORD_SIZE-1:0] w_up_inst  [DEPTH];
   logic [WORD_SIZE-1:0] w_up_pc    [DEPTH];
   logic [1:0]           r_count;
   logic [1:0]           w_wr_idx;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_fetch;
   logic                 w_halt_op;

   assign w_full    = (r_count == 2'(DEPTH));
   assign w_pop     = out_valid && out_ready && !redirect;
   assign w_halt_op = (inst_in[WORD_SIZE-1 -: 4] == HALT_OP);
   // Tail slot after accounting for a same-cycle pop shifting the buffer down.
   assign w_wr_idx  = r_count - {1'b0, w_pop};

   always_comb begin
      w_state_next = r_state;
      w_fetch      = 1'b0;
      halted       = (r_state == ST_HALT);
      case (r_state)
         ST_RUN: begin
            w_fetch = enable && !redirect && (!w_full || w_pop);
            if (w_fetch && w_halt_op) begin
               w_state_next = ST_HALT;
            end
         end
         ST_HALT: begin
            w_state_next = ST_HALT;
         end
         default: begin
            w_state_next = ST_RUN;
         end
      endcase
      if (redirect) begin
         w_state_next = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= '0;
      end else if (redirect) begin
         r_pc <= redirect_pc;
      end else if (w_fetch) begin
         r_pc <= r_pc + {{(WORD_SIZE-1){1'b0}}, 1'b1};
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_up
         if (gi < DEPTH-1) begin : g_next
            assign w_up_inst[gi] = r_buf_inst[gi+1];
            assign w_up_pc[gi]   = r_buf_pc[gi+1];
         end else begin : g_last
            assign w_up_inst[gi] = '0;
            assign w_up_pc[gi]   = '0;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_buf_inst[i] <= '0;
            r_buf_pc[i]   <= '0;
         end
      end else if (redirect) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + {1'b0, w_fetch} - {1'b0, w_pop};
         for (int i = 0; i < DEPTH; i++) begin
            if (w_fetch && (w_wr_idx == 2'(i))) begin
               r_buf_inst[i] <= inst_in;
               r_buf_pc[i]   <= r_pc;
            end else if (w_pop) begin
               r_buf_inst[i] <= w_up_inst[i];
               r_buf_pc[i]   <= w_up_pc[i];
            end
         end
      end
   end

   assign ptr       = r_pc;
   assign out_valid = (r_count != 2'd0);
   assign out_inst  = r_buf_inst[0];
   assign out_pc    = r_buf_pc[0];

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter WORD_SIZE, default 32: instruction and PC width in bits.
REQ-002 Parameter HALT_OP, default 4'b1111: opcode field value that halts fetch.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 enable  input  1: fetch permitted when high.
REQ-006 redirect  input  1: branch/jump redirect request, single-cycle pulse.
REQ-007 redirect_pc  input  WORD_SIZE: new word-index PC when redirect is high.
REQ-008 ptr  output  WORD_SIZE: word address to instruction memory; equals current PC.
REQ-009 inst_in  input  WORD_SIZE: combinational read data from instruction memory at ptr.
REQ-010 out_valid  output  1: buffered instruction available to decode.
REQ-011 out_ready  input  1: decode accepts the head instruction this cycle.
REQ-012 out_inst  output  WORD_SIZE: head instruction.
REQ-013 out_pc  output  WORD_SIZE: PC of the head instruction.
REQ-014 halted  output  1: fetch FSM is in HALT.

Function
REQ-015 PC is a word index, incremented by 1 per fetch, wrapping from 2^WORD_SIZE-1 to 0.
REQ-016 FSM states: RUN, HALT; reset state RUN.
REQ-017 In RUN, a fetch occurs when enable=1, redirect=0 and the buffer has a free slot or its head is being popped in the same cycle.
REQ-018 On fetch: {inst_in, PC} is written to the buffer tail and PC <= PC+1.
REQ-019 Pop occurs when out_valid=1 and out_ready=1; out_inst/out_pc hold stable while out_valid=1 and out_ready=0.
REQ-020 Fetch and pop in the same cycle occur together; occupancy is unchanged.
REQ-021 If the fetched inst_in[31:28] equals HALT_OP, the instruction is still buffered, PC <= PC+1, and the FSM moves to HALT next cycle.
REQ-022 In HALT no fetch occurs, PC holds, halted=1, and buffered entries continue to drain to decode.
REQ-023 redirect=1 has priority over every other event: the buffer is flushed (out_valid=0 next cycle), no fetch, no pop, PC <= redirect_pc, FSM -> RUN.
REQ-024 A pop requested in the redirect cycle is discarded; decode shall not treat it as accepted.
REQ-025 enable=0 blocks only fetch; pop and redirect are unaffected.
REQ-026 out_valid=1 exactly when buffer occupancy is greater than 0.
REQ-027 With PC = 2^WORD_SIZE-1, a fetch produces out_pc = 2^WORD_SIZE-1 and next PC = 0.

Reset
REQ-028 With rst_n low: PC=0, FSM=RUN, buffer empty, out_valid=0, out_inst=0, out_pc=0, halted=0, ptr=0.
REQ-029 Reset asserted mid-operation discards all buffered entries and any pending halt immediately, without waiting for a clock edge.
REQ-030 First fetch occurs on the first rising edge after rst_n deasserts, when enable=1.

Configuration
REQ-031 Macro FETCH_QUEUE_EN defined: the buffer is a 2-entry FIFO; with out_ready=0, two instructions are captured before fetch stalls.
REQ-032 Macro FETCH_QUEUE_EN undefined: the buffer is a single register; with out_ready=0, one instruction is captured and fetch then stalls.
REQ-033 In both builds, sustained enable=1 and out_ready=1 give one instruction per cycle, and REQ-015..REQ-030 hold unchanged.

Verification
REQ-034 Reset, then enable=1, out_ready=1, memory[0..2]=A,B,C -> out_inst A,B,C on consecutive cycles; out_pc 0,1,2; ptr 1,2,3.
REQ-035 out_ready=0 for 4 cycles after reset -> PC stalls at 2 (FETCH_QUEUE_EN) or 1 (undefined); out_inst stays memory[0]; releasing out_ready drains entries in order with no loss.
REQ-036 With memory[3]=32'hF0000000 -> halted=1 from the cycle after that fetch; PC stays 4; entries 0..3 drain; then out_valid=0.
REQ-037 With 2 buffered entries, pulse redirect with redirect_pc=32'h40 -> next cycle out_valid=0, halted=0, ptr=32'h40; next accepted instruction has out_pc=32'h40.
REQ-038 Simultaneous redirect, pop and fetch-eligible cycle -> no pop counted, PC = redirect_pc, buffer empty.
REQ-039 rst_n pulled low asynchronously while HALT with one buffered entry -> out_valid=0, halted=0, ptr=0 before the next clock edge.
